// File: rtl/ram_nc_pkg.sv
// Shared definitions for the no-change RAM request/response controller.
package ram_nc_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 32;
  localparam int CNT_W      = 16;

  // One buffered read response at the default widths.
  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] data;
  } rsp_t;

  // Occupancy counter width for a FIFO of the given depth (holds 0..depth).
  function automatic int occ_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ram_nc_rsp_fifo.sv
// Response FIFO: power-of-two depth, registered head output, occupancy exposed.
module ram_nc_rsp_fifo
  import ram_nc_pkg::*;
#(
  parameter int WIDTH = ADDR_W_DEF + DATA_W_DEF,
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push,
  input  logic [WIDTH-1:0]            din,
  input  logic                        pop,
  output logic [WIDTH-1:0]            dout,
  output logic                        valid,
  output logic [occ_width(DEPTH)-1:0] occ
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = occ_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_ptr_inc;
  logic [OCC_W-1:0] occ_reg;
  logic [OCC_W-1:0] occ_next;
  logic [WIDTH-1:0] head_reg;
  logic             valid_reg;
  logic             pop_eff;

  assign pop_eff    = pop & valid_reg;
  assign rd_ptr_inc = rd_ptr + PTR_W'(1);

  // Occupancy after this cycle's push/pop; simultaneous push and pop cancel.
  always_comb begin
    occ_next = occ_reg;
    case ({push, pop_eff})
      2'b10:   occ_next = occ_reg + OCC_W'(1);
      2'b01:   occ_next = occ_reg - OCC_W'(1);
      default: occ_next = occ_reg;
    endcase
  end

  // Storage array; no reset so it maps onto plain memory.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      occ_reg <= '0;
    end else begin
      if (push)    wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_eff) rd_ptr <= rd_ptr_inc;
      occ_reg <= occ_next;
    end
  end

  // Head register: loads the pushed word when the FIFO is (or becomes) empty
  // underneath it, otherwise the next stored entry on a pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_reg  <= '0;
      valid_reg <= 1'b0;
    end else begin
      if (push && ((occ_reg == '0) || (pop_eff && (occ_reg == OCC_W'(1))))) begin
        head_reg <= din;
      end else if (pop_eff && (occ_reg > OCC_W'(1))) begin
        head_reg <= mem[rd_ptr_inc];
      end
      valid_reg <= (occ_next != '0);
    end
  end

  assign dout  = head_reg;
  assign valid = valid_reg;
  assign occ   = occ_reg;

  // The upstream credit scheme must never push into a full FIFO.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && (occ_reg == OCC_W'(DEPTH))));

endmodule

// File: rtl/ram_nc_port_ctrl.sv
// Request-side controller for a single-port no-change RAM with credit-based
// response buffering so read data captured from the RAM is never dropped.
module ram_nc_port_ctrl
  import ram_nc_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int RSP_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic [CNT_W-1:0]  rd_issued,
  output logic [CNT_W-1:0]  wr_issued
);

  localparam int OCC_W = occ_width(RSP_DEPTH);
  localparam int FW    = ADDR_W + DATA_W;

  logic              acc;
  logic              rd_acc;
  logic              wr_acc;
  logic              pop;
  logic              inflight;
  logic [ADDR_W-1:0] inflight_addr;
  logic [OCC_W-1:0]  occ;
  logic [OCC_W:0]    credit_used;
  logic [FW-1:0]     fifo_din;
  logic [FW-1:0]     fifo_dout;
  logic [CNT_W-1:0]  rd_cnt;
  logic [CNT_W-1:0]  wr_cnt;

  assign pop = rsp_valid & rsp_ready;

  // Entries committed after this cycle: buffered plus the read in flight,
  // minus the one leaving now. Forced low while reset is asserted.
  always_comb begin
    credit_used = {1'b0, occ} + {{OCC_W{1'b0}}, inflight} - {{OCC_W{1'b0}}, pop};
    req_ready   = rst_n & (credit_used < (OCC_W+1)'(RSP_DEPTH));
  end

  assign acc    = req_valid & req_ready;
  assign rd_acc = acc & ~req_we;
  assign wr_acc = acc & req_we;

  assign ram_en   = acc;
  assign ram_we   = wr_acc;
  assign ram_addr = req_addr;
  assign ram_din  = req_wdata;

  // Track the read whose data appears on ram_dout next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight      <= 1'b0;
      inflight_addr <= '0;
    end else begin
      inflight <= rd_acc;
      if (rd_acc) begin
        inflight_addr <= req_addr;
      end
    end
  end

  // Issue counters, free-running and wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else begin
      if (rd_acc) rd_cnt <= rd_cnt + CNT_W'(1);
      if (wr_acc) wr_cnt <= wr_cnt + CNT_W'(1);
    end
  end

  assign rd_issued = rd_cnt;
  assign wr_issued = wr_cnt;

  // ram_dout is only meaningful the cycle after a read; capture it then.
  assign fifo_din = {inflight_addr, ram_dout};

  ram_nc_rsp_fifo #(
    .WIDTH (FW),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (inflight),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (fifo_dout),
    .valid (rsp_valid),
    .occ   (occ)
  );

  assign rsp_data = fifo_dout[DATA_W-1:0];
  assign rsp_addr = fifo_dout[FW-1:DATA_W];

endmodule

// File: tb/tb_ram_nc_port_ctrl.sv
// Scoreboard bench for ram_nc_port_ctrl driving a behavioural no-change RAM.
module tb_ram_nc_port_ctrl;
  import ram_nc_pkg::*;

  localparam int AW = ADDR_W_DEF;
  localparam int DW = DATA_W_DEF;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_data;
  logic [AW-1:0] rsp_addr;
  logic [15:0]   rd_issued, wr_issued;

  ram_nc_port_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RSP_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_addr(rsp_addr),
    .rd_issued(rd_issued), .wr_issued(wr_issued)
  );

  always #5 clk = ~clk;

  // No-change RAM: dout only updates on enabled read cycles.
  logic [DW-1:0] ram_mem [32];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) ram_mem[ram_addr] <= ram_din;
      else        ram_dout <= ram_mem[ram_addr];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_tests = 0;
  int   n_fail  = 0;
  rsp_t exp_q[$];
  bit   quiet = 1'b0;
  bit   seen_valid = 1'b0;
  int   first_valid_cyc = 0;
  int   last_acc_cyc = 0;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: sim time exceeded, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Offer one request until accepted; reads queue their hand-computed result.
  task automatic issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [DW-1:0] exp_rd);
    int   k;
    rsp_t e;
    k = 0;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    @(negedge clk);
    while (!req_ready && k < 100) begin
      k++;
      @(negedge clk);
    end
    if (!req_ready) begin
      n_tests++; n_fail++;
      $display("FAIL req_timeout: got ready=0 expected ready=1 within 100 cycles");
    end else begin
      if (!quiet) $display("[TB] req we=%0d addr=%0d wdata=0x%0h", we, a, d);
      if (!we) begin
        e.addr = a; e.data = exp_rd;
        exp_q.push_back(e);
        last_acc_cyc = cyc;
      end
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    rsp_ready = 1'b1;
    while (exp_q.size() != 0 && k < 50) begin
      k++;
      @(negedge clk);
    end
    @(posedge clk); #1;
    chk(name, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int   acc_cnt;
    int   first_rd_cyc;
    bit   stray;
    rsp_t e;

    // Scoreboard monitor: compares every popped response against the queue.
    fork
      forever begin
        @(negedge clk);
        if (rst_n && rsp_valid) begin
          if (!seen_valid) begin
            seen_valid = 1'b1;
            first_valid_cyc = cyc;
          end
          if (rsp_ready) begin
            if (exp_q.size() == 0) begin
              n_tests++; n_fail++;
              $display("FAIL unexpected_rsp: got addr=%0d data=0x%0h expected none", rsp_addr, rsp_data);
            end else begin
              e = exp_q.pop_front();
              $display("[TB] rsp addr=%0d data=0x%0h", rsp_addr, rsp_data);
              chk("rsp_data", 64'(rsp_data), 64'(e.data));
              chk("rsp_addr", 64'(rsp_addr), 64'(e.addr));
            end
          end
        end
      end
    join_none

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_ram_en", 64'(ram_en), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_data", 64'(rsp_data), 64'd0);
    chk("rst_rsp_addr", 64'(rsp_addr), 64'd0);
    chk("rst_counters", 64'({rd_issued, wr_issued}), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 64'(req_ready), 64'd1);
    @(posedge clk); #1;

    // 8 writes then 8 reads with the consumer always ready.
    rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) issue(1'b1, AW'(i), 32'hA000_0000 + i, '0);
    for (int i = 0; i < 8; i++) begin
      issue(1'b0, AW'(i), '0, 32'hA000_0000 + i);
      if (i == 0) first_rd_cyc = last_acc_cyc;
    end
    drain("drain_seq");
    chk("latency", 64'(first_valid_cyc - first_rd_cyc), 64'd2);
    chk("wr_issued_8", 64'(wr_issued), 64'd8);
    chk("rd_issued_8", 64'(rd_issued), 64'd8);

    // Backpressure: 10 reads offered, exactly 4 credits available.
    rsp_ready = 1'b0;
    acc_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      req_valid = 1'b1; req_we = 1'b0; req_addr = AW'(k);
      @(negedge clk);
      if (req_ready) begin
        acc_cnt++;
        e.addr = AW'(k); e.data = 32'hA000_0000 + k;
        exp_q.push_back(e);
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    chk("bp_accepted", 64'(acc_cnt), 64'd4);
    @(negedge clk);
    chk("bp_ready_low", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_ready_on_pop", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("bp_ready_after_pop", 64'(req_ready), 64'd1);
    chk("bp_left", 64'(exp_q.size()), 64'd3);
    @(posedge clk); #1;
    drain("drain_bp");

    // Read-after-write on consecutive cycles.
    issue(1'b1, 5'd3, 32'h55, '0);
    issue(1'b0, 5'd3, '0, 32'h55);
    drain("drain_raw");

    // Read / write / read on the same address.
    issue(1'b1, 5'd1, 32'h11, '0);
    issue(1'b0, 5'd1, '0, 32'h11);
    issue(1'b1, 5'd1, 32'h22, '0);
    issue(1'b0, 5'd1, '0, 32'h22);
    drain("drain_rwr");
    chk("rd_issued_pre", 64'(rd_issued), 64'd15);
    chk("wr_issued_pre", 64'(wr_issued), 64'd11);

    // Reset with two buffered responses and one read in flight.
    rsp_ready = 1'b0;
    issue(1'b0, 5'd0, '0, 32'hA000_0000);
    issue(1'b0, 5'd1, '0, 32'h22);
    issue(1'b0, 5'd2, '0, 32'hA000_0002);
    chk("pre_rst_valid", 64'(rsp_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rd_issued", 64'(rd_issued), 64'd0);
    chk("rst_wr_issued", 64'(wr_issued), 64'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    stray = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid) stray = 1'b1;
    end
    chk("no_rsp_after_rst", 64'(stray), 64'd0);
    @(posedge clk); #1;

    // Counter wrap with 70,000 writes.
    quiet = 1'b1;
    for (int i = 0; i < 70000; i++) issue(1'b1, AW'(i), DW'(i), '0);
    quiet = 1'b0;
    @(negedge clk);
    chk("wr_wrap", 64'(wr_issued), 64'd4464);
    chk("rd_after_wrap", 64'(rd_issued), 64'd0);
    chk("no_pending", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_nc_port_ctrl.md
# ram_nc_port_ctrl

Request-side controller that sits directly upstream of the team's single-port "no-change" RAM (enable, write-enable, address, data-in; registered data-out that holds its value on write cycles and when disabled). It accepts read/write requests on a valid/ready channel and drives the RAM port. It captures read data one cycle after issue into a response FIFO, then returns it on a valid/ready response channel. Credit-based flow control guarantees no read data is ever lost, at full one-request-per-cycle throughput.

## Interface
Parameters:
- ADDR_W, 5, RAM address width
- DATA_W, 32, RAM data width
- RSP_DEPTH, 4, response FIFO entries; power of two, ≥2

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- req_valid  in  1  request present
- req_ready  out  1  controller can take a request this cycle
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  request address
- req_wdata  in  DATA_W  write data
- ram_en  out  1  RAM enable
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDR_W  RAM address
- ram_din  out  DATA_W  RAM write data
- ram_dout  in  DATA_W  RAM registered read data
- rsp_valid  out  1  read response present
- rsp_ready  in  1  consumer takes response
- rsp_data  out  DATA_W  read data
- rsp_addr  out  ADDR_W  address the data was read from
- rd_issued  out  16  count of reads issued; wraps
- wr_issued  out  16  count of writes issued; wraps

Reset and clock are fixed: one clock `clk`; reset `rst_n` is asynchronous and active-low.

## Operation
- Accept: `acc = req_valid & req_ready`.
- RAM drive is combinational from the request channel:
  - `ram_en = acc`, `ram_we = acc & req_we`.
  - `ram_addr = req_addr`, `ram_din = req_wdata`.
- A read issue sets the 1-bit `inflight` flag and latches `req_addr` into `inflight_addr`.
- Next cycle, `ram_dout` is pushed into the FIFO together with `inflight_addr`. `inflight` then clears, unless another read is issued that same cycle.
- Writes produce no response.
  - Because the RAM is no-change, `ram_dout` is never sampled except in the cycle after a read issue.
- Credit rule: `req_ready = (occ + inflight - pop) < RSP_DEPTH`.
  - `occ` is FIFO occupancy; `pop = rsp_valid & rsp_ready`.
  - `req_ready` is independent of `req_valid` and `req_we`.
  - Writes therefore also stall when credits run out.
- FIFO push and pop in the same cycle: occupancy is unchanged and both operations succeed.
- FIFO overflow is impossible by the credit rule. An SVA assertion checks that a push never occurs while `occ == RSP_DEPTH`.
- Response order equals read-issue order. Writes and reads are executed in acceptance order, so read-after-write to the same address returns the new data.
- `rsp_valid`, `rsp_data` and `rsp_addr` come from the FIFO head and are stable while `rsp_valid & !rsp_ready`.
- `rd_issued` / `wr_issued` increment on each accepted read / write and wrap from 0xFFFF to 0.
- Reset values:
  - `rsp_valid = 0`, `rsp_data = 0`, `rsp_addr = 0`.
  - `inflight = 0`, occupancy 0, both counters 0.
  - `req_ready = 0` while `rst_n` is low; `req_ready = 1` from the first cycle after release.
  - `ram_en = 0` and `ram_we = 0` while in reset.
- Reset mid-operation: the in-flight read and all buffered responses are discarded. The RAM contents are untouched.

## Timing
- Read accepted in cycle N:
  - RAM samples at the end of N.
  - `ram_dout` is valid in N+1 and pushed at the end of N+1.
  - `rsp_valid` is high in N+2.
  - Latency is 2 cycles.
- Write accepted in cycle N: memory is updated at the end of N.
- Throughput is one request per cycle sustained when `rsp_ready` is held high (steady state `occ = 1`, `inflight = 1`, `pop = 1`).
- With `rsp_ready = 0`, the controller accepts exactly RSP_DEPTH reads and then deasserts `req_ready`. It reasserts `req_ready` in the cycle `pop` is high.
- There is no combinational path from `ram_dout` to any output.
- The combinational path from `rsp_ready` to `req_ready` is allowed.

## Structure
- Shared package `ram_nc_pkg`:
  - Default ADDR_W/DATA_W.
  - Counter width localparam CNT_W = 16.
  - Response struct {addr, data}.
- One sub-module, `ram_nc_rsp_fifo`: synchronous FIFO, parameter DEPTH, registered head output, exposes `occ`.
- The top level holds the credit logic, the in-flight register and the counters. The RAM itself is instantiated outside this block.

## Test plan
- Reset, then 8 writes (addr i, data 0xA000_0000+i) followed by 8 reads with `rsp_ready = 1`:
  - Responses arrive in order with `rsp_data` 0xA000_0000..0xA000_0007 and `rsp_addr` 0..7.
  - The first `rsp_valid` appears 2 cycles after the first read is accepted.
  - `wr_issued = 8`, `rd_issued = 8`.
- `rsp_ready = 0` with 10 back-to-back reads offered:
  - Exactly 4 are accepted and `req_ready` drops.
  - Raise `rsp_ready` for 1 cycle: one response pops and `req_ready` returns high the same cycle.
- Write 0x55 to addr 3 and read addr 3 on consecutive cycles: the response is 0x55.
- Interleaved read addr 1 / write addr 1 / read addr 1 with old value 0x11 and new value 0x22: responses are 0x11, then 0x22. The write cycle produces no response.
- Assert `rst_n` low one cycle after a read issue with 2 responses buffered:
  - `rsp_valid` goes 0 asynchronously and no response appears after release.
  - Counters read 0.
- 70,000 writes: `wr_issued` wraps to 70,000 − 65,536 = 4,464.
